// File: rtl/vga_ball_renderer.sv
// Pixel stage after the VGA timing generator: border, background and a
// bouncing square ball, with sync/blank re-aligned to the 2-cycle pipeline.
module vga_ball_renderer #(
   parameter int          H_VISIBLE = 1024,
   parameter int          V_VISIBLE = 768,
   parameter int          BALL_SIZE = 32,
   parameter int          STEP      = 4,
   parameter int          BORDER    = 8,
   parameter int          INIT_X    = 496,
   parameter int          INIT_Y    = 368,
   parameter logic [23:0] BALL_RGB  = 24'hFF2000,
   parameter logic [23:0] BG_RGB    = 24'h002040
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] vga_x,
   input  logic [31:0] vga_y,
   input  logic        vga_hs,
   input  logic        vga_vs,
   input  logic        vga_blank,
   input  logic        move_en,
   output logic [7:0]  vga_r,
   output logic [7:0]  vga_g,
   output logic [7:0]  vga_b,
   output logic        out_hs,
   output logic        out_vs,
   output logic        out_blank,
   output logic        frame_tick
);

   localparam logic [11:0] HV  = 12'(H_VISIBLE);
   localparam logic [11:0] VV  = 12'(V_VISIBLE);
   localparam logic [11:0] BS  = 12'(BALL_SIZE);
   localparam logic [11:0] ST  = 12'(STEP);
   localparam logic [11:0] BD  = 12'(BORDER);
   localparam logic [10:0] ST1 = 11'(STEP);

   typedef enum logic [1:0] {WAIT, UPD_X, UPD_Y} state_t;

   typedef struct packed {
      logic in_ball;
      logic in_border;
      logic hs;
      logic vs;
      logic blank;
   } s1_t;

   typedef struct packed {
      logic [10:0] pos;
      logic        dir;
   } mv_t;

   state_t      state, state_nx;
   logic [10:0] ball_x, ball_y, bx_nx, by_nx;
   logic        dir_x, dir_y, dx_nx, dy_nx;
   logic        vs_q, vs_edge, tick_nx;
   mv_t         mx, my;
   s1_t         s1, s1_nx;
   logic [23:0] rgb;
   logic        s2_hs, s2_vs, s2_blank;
   logic [11:0] px, py;
   logic        unused_hi;

   // dir=1 moves toward larger coordinates
   function automatic mv_t step(input logic [10:0] pos,
                                input logic        dir,
                                input logic [11:0] lim);
      mv_t r;
      r.pos = pos;
      r.dir = dir;
      if (dir) begin
         if ({1'b0, pos} + BS + ST > lim) begin
            r.pos = 11'(lim - BS);
            r.dir = 1'b0;
         end else begin
            r.pos = pos + ST1;
         end
      end else if (pos < ST1) begin
         r.pos = '0;
         r.dir = 1'b1;
      end else begin
         r.pos = pos - ST1;
      end
      return r;
   endfunction

   assign px        = {1'b0, vga_x[10:0]};
   assign py        = {1'b0, vga_y[10:0]};
   assign unused_hi = ^{vga_x[31:11], vga_y[31:11]};
   assign vs_edge   = vs_q & ~vga_vs;
   assign mx        = step(ball_x, dir_x, HV);
   assign my        = step(ball_y, dir_y, VV);

   always_comb begin
      s1_nx.in_ball = (px >= {1'b0, ball_x}) &&
                      (px <  {1'b0, ball_x} + BS) &&
                      (py >= {1'b0, ball_y}) &&
                      (py <  {1'b0, ball_y} + BS);
      s1_nx.in_border = (px < BD) || (px >= HV - BD) ||
                        (py < BD) || (py >= VV - BD);
      s1_nx.hs    = vga_hs;
      s1_nx.vs    = vga_vs;
      s1_nx.blank = vga_blank;
   end

   always_comb begin
      state_nx = state;
      bx_nx    = ball_x;
      by_nx    = ball_y;
      dx_nx    = dir_x;
      dy_nx    = dir_y;
      tick_nx  = 1'b0;
      case (state)
         WAIT: begin
            if (vs_edge) state_nx = UPD_X;
         end
         UPD_X: begin
            if (move_en) begin
               bx_nx = mx.pos;
               dx_nx = mx.dir;
            end
            state_nx = UPD_Y;
         end
         UPD_Y: begin
            if (move_en) begin
               by_nx = my.pos;
               dy_nx = my.dir;
            end
            tick_nx  = 1'b1;
            state_nx = WAIT;
         end
         default: state_nx = WAIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= WAIT;
         ball_x     <= 11'(INIT_X);
         ball_y     <= 11'(INIT_Y);
         dir_x      <= 1'b1;
         dir_y      <= 1'b1;
         vs_q       <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         state      <= state_nx;
         ball_x     <= bx_nx;
         ball_y     <= by_nx;
         dir_x      <= dx_nx;
         dir_y      <= dy_nx;
         vs_q       <= vga_vs;
         frame_tick <= tick_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         s1       <= '{in_ball: 1'b0, in_border: 1'b0,
                       hs: 1'b1, vs: 1'b1, blank: 1'b0};
         rgb      <= '0;
         s2_hs    <= 1'b1;
         s2_vs    <= 1'b1;
         s2_blank <= 1'b0;
      end else begin
         s1 <= s1_nx;
         if (!s1.blank)         rgb <= '0;
         else if (s1.in_ball)   rgb <= BALL_RGB;
         else if (s1.in_border) rgb <= 24'hFFFFFF;
         else                   rgb <= BG_RGB;
         s2_hs    <= s1.hs;
         s2_vs    <= s1.vs;
         s2_blank <= s1.blank;
      end
   end

   assign {vga_r, vga_g, vga_b} = rgb;
   assign out_hs    = s2_hs;
   assign out_vs    = s2_vs;
   assign out_blank = s2_blank;

endmodule

// File: tb/tb_vga_ball_renderer.sv
// Directed bench for vga_ball_renderer: pixel colours, latency, motion,
// bounces, hold and mid-update reset, all against hand-computed values.
module tb_vga_ball_renderer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] vga_x = '0;
   logic [31:0] vga_y = '0;
   logic        vga_hs = 1'b1;
   logic        vga_vs = 1'b1;
   logic        vga_blank = 1'b0;
   logic        move_en = 1'b0;
   logic [7:0]  vga_r, vga_g, vga_b;
   logic        out_hs, out_vs, out_blank, frame_tick;
   logic [23:0] rgb;

   int total = 0;
   int bad = 0;

   localparam logic [23:0] BALL = 24'hFF2000;
   localparam logic [23:0] BG   = 24'h002040;
   localparam logic [23:0] WH   = 24'hFFFFFF;
   localparam logic [23:0] BK   = 24'h000000;

   vga_ball_renderer dut (
      .clk(clk), .reset(reset),
      .vga_x(vga_x), .vga_y(vga_y),
      .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank(vga_blank),
      .move_en(move_en),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .out_hs(out_hs), .out_vs(out_vs), .out_blank(out_blank),
      .frame_tick(frame_tick)
   );

   assign rgb = {vga_r, vga_g, vga_b};

   always #5 clk = ~clk;

   task automatic test_reset;
      @(negedge clk);
      reset = 1'b0;
      vga_hs = 1'b0; vga_vs = 1'b0; vga_blank = 1'b1;
      vga_x = 500; vga_y = 380;
      repeat (3) @(negedge clk);
      total++;
      if (rgb !== BK) begin
         bad++; $display("FAIL reset_rgb: got %h want %h", rgb, BK);
      end
      total++;
      if (out_hs !== 1'b1) begin
         bad++; $display("FAIL reset_hs: got %b want 1", out_hs);
      end
      total++;
      if (out_vs !== 1'b1) begin
         bad++; $display("FAIL reset_vs: got %b want 1", out_vs);
      end
      total++;
      if (out_blank !== 1'b0) begin
         bad++; $display("FAIL reset_blank: got %b want 0", out_blank);
      end
      total++;
      if (frame_tick !== 1'b0) begin
         bad++; $display("FAIL reset_tick: got %b want 0", frame_tick);
      end
      vga_hs = 1'b1; vga_vs = 1'b1; vga_blank = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   // streamed pixels: output at negedge i reflects inputs driven at i-2
   task automatic test_pixels;
      int px[17] = '{0, 500, 100, 7, 8, 1015, 1016, 100, 100, 100, 100,
                     1023, 496, 495, 527, 528, 527};
      int py[17] = '{0, 380, 100, 100, 100, 100, 100, 7, 8, 759, 760,
                     767, 368, 368, 399, 399, 400};
      logic [23:0] ex[17] = '{WH, BALL, BG, WH, BG, BG, WH, WH, BG, BG, WH,
                              WH, BALL, BG, BALL, BG, BG};
      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            total++;
            if (rgb !== ex[i-2]) begin
               bad++;
               $display("FAIL pixel(%0d,%0d): got %h want %h",
                        px[i-2], py[i-2], rgb, ex[i-2]);
            end
            total++;
            if (out_hs !== logic'((i - 2) % 2)) begin
               bad++;
               $display("FAIL hs_delay[%0d]: got %b want %b",
                        i - 2, out_hs, logic'((i - 2) % 2));
            end
         end
         if (i < 17) begin
            vga_x = px[i]; vga_y = py[i];
            vga_blank = 1'b1;
            vga_hs = logic'(i % 2);
         end
      end
      vga_hs = 1'b1; vga_blank = 1'b0;
   endtask

   task automatic test_blank;
      int px[5] = '{1100, 500, 0, 500, 100};
      int py[5] = '{10, 380, 0, 380, 100};
      logic pb[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [23:0] ex[5] = '{BK, BK, BK, BALL, BK};
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            total++;
            if (rgb !== ex[i-2]) begin
               bad++;
               $display("FAIL blank_rgb(%0d,%0d): got %h want %h",
                        px[i-2], py[i-2], rgb, ex[i-2]);
            end
            total++;
            if (out_blank !== pb[i-2]) begin
               bad++;
               $display("FAIL blank_delay[%0d]: got %b want %b",
                        i - 2, out_blank, pb[i-2]);
            end
         end
         if (i < 5) begin
            vga_x = px[i]; vga_y = py[i]; vga_blank = pb[i];
         end
      end
      vga_blank = 1'b0;
   endtask

   task automatic check_ball(input int x, input int y);
      int  qx[6] = '{x, x + 31, x + 32, x, x - 1, x};
      int  qy[6] = '{y, y + 31, y, y + 32, y, y - 1};
      logic inb[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic use_p[6] = '{1'b1, 1'b1, 1'b1, 1'b1, x > 0, y > 0};
      for (int i = 0; i < 6; i++) begin
         if (use_p[i]) begin
            @(negedge clk);
            vga_x = qx[i]; vga_y = qy[i]; vga_blank = 1'b1;
            repeat (2) @(negedge clk);
            total++;
            if (inb[i] && rgb !== BALL) begin
               bad++;
               $display("FAIL ball_in(%0d,%0d): got %h want %h",
                        qx[i], qy[i], rgb, BALL);
            end else if (!inb[i] && rgb === BALL) begin
               bad++;
               $display("FAIL ball_out(%0d,%0d): got %h want not %h",
                        qx[i], qy[i], rgb, BALL);
            end
         end
      end
      @(negedge clk);
      vga_blank = 1'b0;
   endtask

   task automatic run_frames(input int n);
      int t = 0;
      repeat (n) begin
         @(negedge clk);
         vga_vs = 1'b0;
         repeat (5) begin
            @(negedge clk);
            if (frame_tick === 1'b1) t++;
         end
         vga_vs = 1'b1;
         repeat (2) begin
            @(negedge clk);
            if (frame_tick === 1'b1) t++;
         end
      end
      total++;
      if (t != n) begin
         bad++;
         $display("FAIL tick_count: got %0d want %0d", t, n);
      end
   endtask

   task automatic test_motion;
      int t;
      int at;
      move_en = 1'b1;
      for (int f = 0; f < 3; f++) begin
         @(negedge clk);
         vga_vs = 1'b0;
         t = 0; at = 0;
         for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (f == 0 && c == 1) begin
               total++;
               if (out_vs !== 1'b1) begin
                  bad++; $display("FAIL vs_delay1: got %b want 1", out_vs);
               end
            end
            if (f == 0 && c == 2) begin
               total++;
               if (out_vs !== 1'b0) begin
                  bad++; $display("FAIL vs_delay2: got %b want 0", out_vs);
               end
            end
            if (frame_tick === 1'b1) begin
               t++; at = c;
            end
         end
         total++;
         if (t != 1 || at != 3) begin
            bad++;
            $display("FAIL tick_timing f%0d: got %0d ticks at %0d want 1 at 3",
                     f, t, at);
         end
         vga_vs = 1'b1;
         repeat (2) @(negedge clk);
      end
      check_ball(508, 380);
   endtask

   task automatic test_right_bounce;
      run_frames(120);
      check_ball(988, 616);
      run_frames(1);
      check_ball(992, 612);
      run_frames(1);
      check_ball(992, 608);
      run_frames(1);
      check_ball(988, 604);
   endtask

   task automatic test_hold;
      move_en = 1'b0;
      run_frames(2);
      check_ball(988, 604);
      move_en = 1'b1;
   endtask

   task automatic test_top_bounce;
      run_frames(150);
      check_ball(388, 4);
      run_frames(1);
      check_ball(384, 0);
      run_frames(1);
      check_ball(380, 0);
      run_frames(1);
      check_ball(376, 4);
   endtask

   task automatic test_reset_mid;
      int t = 0;
      @(negedge clk);
      vga_vs = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      vga_vs = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      if (frame_tick === 1'b1) t++;
      repeat (6) begin
         @(negedge clk);
         if (frame_tick === 1'b1) t++;
      end
      total++;
      if (t != 0) begin
         bad++; $display("FAIL reset_mid_tick: got %0d want 0", t);
      end
      check_ball(496, 368);
      run_frames(1);
      check_ball(500, 372);
   endtask

   initial begin
      test_reset;
      test_pixels;
      test_blank;
      test_motion;
      test_right_bounce;
      test_hold;
      test_top_bounce;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
